// File: rtl/sad_pkg.sv
// Shared constants and types for the SAD minimum search block.
// Width helpers, FSM state encoding and the SAD reset value.
package sad_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

  function automatic int row_w(input int n);
    return 8 + clog2(n);
  endfunction

  function automatic int sad_w(input int n);
    return 8 + 2 * clog2(n);
  endfunction

  localparam int DEF_ARRAY_SIZE = 16;
  localparam int ROW_W = row_w(DEF_ARRAY_SIZE);
  localparam int SAD_W = sad_w(DEF_ARRAY_SIZE);
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ad_adder_tree.sv
// Registered pairwise reduction of one AD row; row_sum lags in_valid
// by log2(ARRAY_SIZE) cycles. Ports: clk, rst_n, in_valid, ad -> out_valid, row_sum.
module ad_adder_tree
  import sad_pkg::*;
#(
  parameter int ARRAY_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [ARRAY_SIZE*8-1:0]       ad,
  output logic                          out_valid,
  output logic [row_w(ARRAY_SIZE)-1:0]  row_sum
);

  localparam int L    = clog2(ARRAY_SIZE);
  localparam int RW   = row_w(ARRAY_SIZE);
  localparam int HALF = ARRAY_SIZE / 2;

  logic [RW-1:0] leaf [ARRAY_SIZE];
  logic [RW-1:0] node [L][HALF];
  logic [L-1:0]  vld;

  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++)
      leaf[i] = RW'(ad[8*i +: 8]);
  end

  // node[k] holds level k+1 of the tree: HALF>>k live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < L; k++)
        for (int i = 0; i < HALF; i++)
          node[k][i] <= '0;
    end else begin
      vld <= (vld << 1) | L'(in_valid);
      for (int i = 0; i < HALF; i++)
        node[0][i] <= leaf[2*i] + leaf[2*i+1];
      for (int k = 1; k < L; k++)
        for (int i = 0; i < (HALF >> k); i++)
          node[k][i] <= node[k-1][2*i] + node[k-1][2*i+1];
    end
  end

  assign out_valid = vld[L-1];
  assign row_sum   = node[L-1][0];

endmodule

// File: rtl/sad_min_search.sv
// Row-wise SAD accumulation and raster-scan minimum tracking.
// In: start, ad_valid, ad. Out: sad_valid/sad, min_sad, mv_x/mv_y, busy, done.
module sad_min_search
  import sad_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int SR_W       = 32,
  parameter int SR_H       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          ad_valid,
  input  logic [ARRAY_SIZE*8-1:0]       ad,
  output logic                          sad_valid,
  output logic [sad_w(ARRAY_SIZE)-1:0]  sad,
  output logic [sad_w(ARRAY_SIZE)-1:0]  min_sad,
  output logic [clog2(SR_W)-1:0]        mv_x,
  output logic [clog2(SR_H)-1:0]        mv_y,
  output logic                          busy,
  output logic                          done
);

  localparam int L     = clog2(ARRAY_SIZE);
  localparam int RW    = row_w(ARRAY_SIZE);
  localparam int SW    = sad_w(ARRAY_SIZE);
  localparam int XW    = clog2(SR_W);
  localparam int YW    = clog2(SR_H);
  localparam int TOTAL = SR_W * SR_H * ARRAY_SIZE;
  localparam int BW    = clog2(TOTAL + 1);

  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] beat_cnt;
  logic [L-1:0]  row_cnt;
  logic [SW-1:0] acc;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          feed;
  logic          start_ok;
  logic          tree_valid;
  logic [RW-1:0] row_sum;
  logic [SW-1:0] row_ext;
  logic          last_row;
  logic          last_x;
  logic          last_cand;

  // Beats past the final candidate's last row never enter the tree.
  assign start_ok  = start && (state_q == ST_IDLE);
  assign feed      = ad_valid && (state_q == ST_RUN)
                     && (beat_cnt < BW'(TOTAL));
  assign row_ext   = SW'(row_sum);
  assign last_row  = (row_cnt == L'(ARRAY_SIZE - 1));
  assign last_x    = (x_cnt == XW'(SR_W - 1));
  assign last_cand = last_x && (y_cnt == YW'(SR_H - 1));

  ad_adder_tree #(
    .ARRAY_SIZE (ARRAY_SIZE)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (feed),
    .ad        (ad),
    .out_valid (tree_valid),
    .row_sum   (row_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (sad_valid && last_cand)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      row_cnt   <= '0;
      acc       <= '0;
      sad       <= '0;
      sad_valid <= 1'b0;
      min_sad   <= '1;
      mv_x      <= '0;
      mv_y      <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
    end else begin
      sad_valid <= 1'b0;
      if (start_ok) begin
        beat_cnt <= '0;
        row_cnt  <= '0;
        acc      <= '0;
        x_cnt    <= '0;
        y_cnt    <= '0;
        min_sad  <= '1;
      end
      if (feed)
        beat_cnt <= beat_cnt + 1'b1;
      if (tree_valid) begin
        row_cnt <= row_cnt + 1'b1;
        if (row_cnt == '0)
          acc <= row_ext;
        else
          acc <= acc + row_ext;
        if (last_row) begin
          sad       <= acc + row_ext;
          sad_valid <= 1'b1;
        end
      end
      // Strict compare: on a tie the earlier raster position stays.
      if (sad_valid && (state_q == ST_RUN)) begin
        if (sad < min_sad) begin
          min_sad <= sad;
          mv_x    <= x_cnt;
          mv_y    <= y_cnt;
        end
        if (last_x) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search (16x16 PE rows, 4x4 search).
// Random and directed candidate data checked against a per-candidate sum model.
module tb_sad_min_search;

  localparam int AS = 16;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int NC = SW * SH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ad_valid = 1'b0;
  logic [127:0]  ad = '0;
  logic          sad_valid;
  logic [15:0]   sad;
  logic [15:0]   min_sad;
  logic [1:0]    mv_x;
  logic [1:0]    mv_y;
  logic          busy;
  logic          done;

  sad_min_search #(
    .ARRAY_SIZE (AS),
    .SR_W       (SW),
    .SR_H       (SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ad_valid  (ad_valid),
    .ad        (ad),
    .sad_valid (sad_valid),
    .sad       (sad),
    .min_sad   (min_sad),
    .mv_x      (mv_x),
    .mv_y      (mv_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int done_cnt;
  int beat_cyc;
  logic [15:0] sad_q [$];
  int          sad_cyc [$];

  logic [127:0] rows [NC][AS];
  int exp_sad [NC];
  int exp_min;
  int exp_x;
  int exp_y;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && sad_valid) begin
      sad_q.push_back(sad);
      sad_cyc.push_back(cyc);
    end
    if (rst_n && done)
      done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Candidate c sits at x = c % SW, y = c / SW in raster order.
  task automatic gen(input int mode);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < AS; r++) begin
        case (mode)
          0: rows[c][r] = (c == 9) ? {16{8'h01}} : {16{8'h02}};
          1: begin
            rows[c][r] = '0;
            if (r == 0) begin
              if (c == 4 || c == 15) begin
                rows[c][r][7:0] = 8'd100;
              end else begin
                rows[c][r][7:0]  = 8'd250;
                rows[c][r][15:8] = 8'd250;
              end
            end
          end
          default: begin
            rows[c][r] = {$urandom(), $urandom(),
                          $urandom(), $urandom()};
            if (mode == 3 && c == 0)
              rows[c][r] = {16{8'hFF}};
          end
        endcase
      end
  endtask

  task automatic model();
    exp_min = 65535;
    exp_x   = 0;
    exp_y   = 0;
    for (int c = 0; c < NC; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < AS; r++)
        for (int i = 0; i < AS; i++)
          s += int'(rows[c][r][8*i +: 8]);
      exp_sad[c] = s;
      if (s < exp_min) begin
        exp_min = s;
        exp_x   = c % SW;
        exp_y   = c / SW;
      end
    end
  endtask

  task automatic run_search(input int gap_pct,
                            input bit disturb,
                            input bit timing);
    int n;
    model();
    sad_q.delete();
    sad_cyc.delete();
    done_cnt = 0;
    if (disturb) begin
      repeat (3) begin
        @(negedge clk);
        ad_valid = 1'b1;
        ad = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    @(negedge clk);
    start    = 1'b1;
    ad_valid = disturb;
    ad = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    start    = 1'b0;
    ad_valid = 1'b0;
    chk("busy_run", busy, 1);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < AS; r++) begin
        while ($urandom_range(99) < gap_pct) begin
          ad_valid = 1'b0;
          start = disturb && ($urandom_range(3) == 0);
          @(negedge clk);
          start = 1'b0;
        end
        ad_valid = 1'b1;
        ad       = rows[c][r];
        start    = disturb && c == 5 && r == 3;
        if (c == 0 && r == AS - 1)
          beat_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
      end
    if (disturb) begin
      repeat (4) begin
        ad_valid = 1'b1;
        ad = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
      end
    end
    ad_valid = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("min_sad", min_sad, exp_min);
    chk("mv_x", mv_x, exp_x);
    chk("mv_y", mv_y, exp_y);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, 1);
    chk("sad_cnt", sad_q.size(), NC);
    chk("hold_min", min_sad, exp_min);
    for (int c = 0; c < NC && c < sad_q.size(); c++)
      chk($sformatf("sad_seq[%0d]", c), sad_q[c], exp_sad[c]);
    if (timing && sad_cyc.size() > 0)
      chk("latency", sad_cyc[0] - beat_cyc, 5);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    chk("rst_sad_valid", sad_valid, 0);
    chk("rst_sad", sad, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_min_sad", min_sad, 16'hFFFF);
    chk("rst_mv_x", mv_x, 0);
    chk("rst_mv_y", mv_y, 0);
    @(negedge clk);
    rst_n = 1'b1;

    gen(3);
    run_search(0, 1'b0, 1'b1);
    if (sad_q.size() > 0)
      chk("sad_all_ff", sad_q[0], 65280);

    gen(0);
    run_search(0, 1'b0, 1'b0);
    chk("min_256", min_sad, 256);
    chk("mv_x_1", mv_x, 1);
    chk("mv_y_2", mv_y, 2);

    gen(1);
    run_search(0, 1'b0, 1'b0);
    chk("tie_min", min_sad, 100);
    chk("tie_mv_x", mv_x, 0);
    chk("tie_mv_y", mv_y, 1);

    gen(0);
    run_search(50, 1'b0, 1'b0);

    gen(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 7 * AS + 5; b++) begin
      ad_valid = 1'b1;
      ad = rows[b / AS][b % AS];
      @(negedge clk);
    end
    ad_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sad_valid", sad_valid, 0);
    chk("mid_rst_sad", sad, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_min", min_sad, 16'hFFFF);
    chk("mid_rst_mv_x", mv_x, 0);
    chk("mid_rst_mv_y", mv_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gen(2);
    run_search(0, 1'b0, 1'b1);

    gen(0);
    run_search(30, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sad_min_search.md
Name: sad_min_search

Overview:
- Consumes the packed per-PE absolute-difference bus produced by one PE line, one row of ARRAY_SIZE ADs per valid beat.
- Reduces each row with a pipelined adder tree and accumulates ARRAY_SIZE rows into one candidate SAD.
- Tracks the minimum SAD and its candidate position over a raster scan of SR_W x SR_H candidates.
- Sits directly downstream of the PE line; its result feeds the motion-vector output stage.

Parameters:
- ARRAY_SIZE, 16: ADs per row and rows per candidate. Must be a power of 2, >= 2.
- SR_W, 32: candidate positions per search row (mv_x range 0..SR_W-1).
- SR_H, 32: candidate rows (mv_y range 0..SR_H-1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new search. Accepted only in IDLE.
- ad_valid  input  1  the ad bus carries one valid row this cycle.
- ad  input  ARRAY_SIZE*8  packed ADs; AD i is at bits [8*(i+1)-1:8*i].
- sad_valid  output  1  one-cycle pulse when a candidate SAD completes.
- sad  output  SAD_W  SAD of the candidate just completed.
- min_sad  output  SAD_W  best SAD so far.
- mv_x  output  clog2(SR_W)  x position of the best candidate.
- mv_y  output  clog2(SR_H)  y position of the best candidate.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the search completes; min_sad/mv_x/mv_y are final.

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-search. Reset values:
  - state IDLE; all pipeline valid bits cleared.
  - sad_valid=0, sad=0, done=0, busy=0.
  - min_sad = all ones; mv_x = 0, mv_y = 0.
- Widths: L = log2(ARRAY_SIZE); ROW_W = 8+L; SAD_W = 8+2L (16x16 gives 12 and 16 bits). All sums are unsigned and cannot overflow.
- Adder tree: L levels, each a pairwise add registered at its output, so one row sum appears L cycles after its ad_valid beat. The valid bit travels with the data.
- Accumulator:
  - A row counter (0..ARRAY_SIZE-1) advances on each valid tree output.
  - On row 0, acc = row_sum; otherwise acc = acc + row_sum.
  - On the last row, the result is registered into sad and sad_valid pulses.
  - Total latency is L+1 cycles from the candidate's final ad_valid beat to sad_valid.
- Min update:
  - Evaluated on the sad_valid cycle, with a result visible next cycle.
  - Update only if sad < min_sad (strictly less). On a tie the earlier candidate wins.
  - The candidate position comes from x/y counters that advance on each completed candidate: x wraps at SR_W-1 and then y increments.
- FSM:
  - IDLE: busy=0. On start → RUN; clear the counters and set min_sad to all ones. In IDLE, ad_valid is ignored and nothing enters the pipeline.
  - RUN: busy=1. After the min update for candidate (SR_W-1, SR_H-1) → DONE.
  - DONE: done=1 for one cycle, then → IDLE. Results hold until the next start.
- start in RUN or DONE is ignored. start and ad_valid in the same IDLE cycle: that beat is dropped; the first row is taken on the next ad_valid.
- Gaps in ad_valid are allowed anywhere; accumulation resumes on the next beat.
- ad_valid beats beyond the last candidate's row count are ignored.

Decomposition:
- Package sad_pkg holds: the clog2 constant function, derived widths ROW_W/SAD_W, the FSM state encoding (IDLE/RUN/DONE), and the SAD_MAX constant.
- One sub-module, ad_adder_tree (parameters ARRAY_SIZE; ports clk, rst_n, in_valid, ad, out_valid, row_sum). It holds the registered reduction tree and its valid pipeline.
- The accumulator, counters, FSM and min logic stay in the top level.

Test Plan (ARRAY_SIZE=16, SR_W=SR_H=4 unless noted):
- Reset values, then start, then 16 consecutive beats of ad all 0xFF → single sad_valid exactly 5 cycles after the 16th beat, with sad=65280.
- All 16 candidates, each with every AD=0x02 except candidate (x=1,y=2), which uses 0x01 → min_sad=256, mv_x=1, mv_y=2, done pulses once, busy falls.
- Tie: candidates (0,1) and (3,3) both have sad=100, all others 500 → mv_x=0, mv_y=1.
- Random ad_valid gaps (≈50% duty) with the stimulus of scenario 2 → identical results; sad_valid count = 16.
- Deassert rst_n mid-candidate 7 → all outputs return to reset values immediately. A new start runs a full search correctly with no stale accumulation.
- start pulsed during RUN, and ad_valid in IDLE → ignored; the row/candidate counters and the sad sequence are unaffected.
